// File: rtl/gzip_pkg.sv
// Shared constants for the gzip stream monitor: FSM encodings, CRC32 parameters,
// debug_reg field layout and deflate block-type codes.
package gzip_pkg;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_RUN   = 3'd1;
   localparam logic [2:0] ST_DRAIN = 3'd2;
   localparam logic [2:0] ST_DONE  = 3'd3;
   localparam logic [2:0] ST_ERR   = 3'd4;

   localparam logic [31:0] CRC32_POLY = 32'hEDB88320;
   localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;

   localparam int unsigned DBG_DONE_BIT  = 0;
   localparam int unsigned DBG_BTERR_BIT = 1;
   localparam int unsigned DBG_BSERR_BIT = 2;
   localparam int unsigned DBG_ISIZE_LSB = 8;
   localparam int unsigned DBG_CRC_LSB   = 40;
   localparam int unsigned DBG_BSIZE_LSB = 72;

   localparam logic [1:0] BTYPE_STORED = 2'b00;
   localparam logic [1:0] BTYPE_RSVD   = 2'b11;

   function automatic logic [31:0] byte_swap32(input logic [31:0] x);
      return {x[7:0], x[15:8], x[23:16], x[31:24]};
   endfunction

endpackage

// File: rtl/gzip_stream_monitor_if.sv
// Byte-stream handshake bundle (data/valid/last/blk_end forward, ready backward).
interface gzip_stream_monitor_if;
   logic [7:0] data;
   logic       valid;
   logic       last;
   logic       blk_end;
   logic       ready;

   modport master (output data, valid, last, blk_end, input ready);
   modport slave  (input data, valid, last, blk_end, output ready);
endinterface

// File: rtl/crc32_byte_update.sv
// One-byte CRC32 step, reflected polynomial, LSB first. Built only with GZIP_MON_CRC_EN.
`ifdef GZIP_MON_CRC_EN
module crc32_byte_update
   import gzip_pkg::*;
(
   input  logic [31:0] crc_in,
   input  logic [7:0]  byte_in,
   output logic [31:0] crc_out
);

   always_comb begin
      logic [31:0] c;
      c = crc_in ^ {24'h0, byte_in};
      for (int unsigned i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
      end
      crc_out = c;
   end

endmodule
`endif

// File: rtl/gzip_stream_monitor.sv
// Gzip-domain stream tap: one-stage register slice plus per-stream ISIZE/CRC32/block statistics
// packed into debug_reg. CRC32 is present only when GZIP_MON_CRC_EN is defined.
module gzip_stream_monitor
   import gzip_pkg::*;
#(
   parameter logic [23:0] MAX_STORED_LEN = 24'd65535,
   parameter int unsigned BLK_CNT_W      = 24
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [1:0]            btype,
   input  logic                  rev_endianess,
   gzip_stream_monitor_if.slave  in_if,
   gzip_stream_monitor_if.master out_if,
   output logic [95:0]           debug_reg
);

   logic [2:0]           r_state;
   logic [2:0]           w_state_nxt;
   logic                 r_live;
   logic [7:0]           r_out_data;
   logic                 r_out_valid;
   logic                 r_out_last;
   logic                 r_out_blk_end;
   logic [31:0]          r_isize;
   logic [BLK_CNT_W-1:0] r_blk_cnt;
   logic [BLK_CNT_W-1:0] r_bsize;
   logic                 r_done;
   logic                 r_bterr;
   logic                 r_bserr;
   logic                 w_in_ready;
   logic                 w_accept;
   logic                 w_deliver;
   logic                 w_start;
   logic                 w_drop;
   logic                 w_load;
   logic [24:0]          w_cnt_sum;
   logic [BLK_CNT_W-1:0] w_cnt_inc;
   logic                 w_len_over;
   logic [31:0]          w_crc_field;

   // r_live keeps in_ready low while reset is applied and for the first cycle after it
   always_comb begin
      case (r_state)
         ST_IDLE, ST_DONE: w_in_ready = !r_out_valid;
         ST_RUN:           w_in_ready = !r_out_valid || out_if.ready;
         default:          w_in_ready = 1'b0;
      endcase
      w_in_ready = w_in_ready && r_live;
   end

   assign w_accept  = in_if.valid && w_in_ready;
   assign w_deliver = r_out_valid && out_if.ready;
   assign w_start   = w_accept && (r_state == ST_IDLE || r_state == ST_DONE);
   assign w_drop    = w_start && (btype == BTYPE_RSVD);
   assign w_load    = w_accept && !w_drop;

   assign w_cnt_sum  = 25'(r_blk_cnt) + 25'd1;
   assign w_cnt_inc  = (&r_blk_cnt) ? r_blk_cnt : w_cnt_sum[BLK_CNT_W-1:0];
   assign w_len_over = (btype == BTYPE_STORED) && (w_cnt_sum > {1'b0, MAX_STORED_LEN});

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE, ST_DONE:
            if (w_accept) w_state_nxt = w_drop ? ST_ERR : (in_if.last ? ST_DRAIN : ST_RUN);
         ST_RUN:
            if (w_accept && in_if.last) w_state_nxt = ST_DRAIN;
         ST_DRAIN:
            if (w_deliver && r_out_last) w_state_nxt = ST_DONE;
         default:
            w_state_nxt = r_state;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_IDLE;
         r_live        <= 1'b0;
         r_out_data    <= '0;
         r_out_valid   <= 1'b0;
         r_out_last    <= 1'b0;
         r_out_blk_end <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_live  <= 1'b1;
         if (w_load) begin
            r_out_data    <= in_if.data;
            r_out_last    <= in_if.last;
            r_out_blk_end <= in_if.blk_end;
            r_out_valid   <= 1'b1;
         end else if (w_deliver) begin
            r_out_valid   <= 1'b0;
         end
      end
   end

   // Stream start only happens with the slice empty, so it never coincides with a delivery
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_isize   <= '0;
         r_blk_cnt <= '0;
         r_bsize   <= '0;
         r_done    <= 1'b0;
         r_bterr   <= 1'b0;
         r_bserr   <= 1'b0;
      end else begin
         if (w_drop) r_bterr <= 1'b1;
         if (w_start) begin
            r_isize   <= '0;
            r_blk_cnt <= '0;
            r_bsize   <= '0;
            r_done    <= 1'b0;
            r_bserr   <= 1'b0;
         end else if (w_deliver) begin
            r_isize <= r_isize + 32'd1;
            if (r_out_blk_end || r_out_last) begin
               r_bsize   <= w_cnt_inc;
               r_blk_cnt <= '0;
            end else begin
               r_blk_cnt <= w_cnt_inc;
            end
            if (w_len_over) r_bserr <= 1'b1;
            if (r_out_last) r_done <= 1'b1;
         end
      end
   end

`ifdef GZIP_MON_CRC_EN
   logic [31:0] r_crc;
   logic [31:0] w_crc_next;

   crc32_byte_update u_crc (
      .crc_in  (r_crc),
      .byte_in (r_out_data),
      .crc_out (w_crc_next)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_crc <= CRC32_INIT;
      end else if (w_start) begin
         r_crc <= CRC32_INIT;
      end else if (w_deliver) begin
         r_crc <= w_crc_next;
      end
   end

   assign w_crc_field = ~r_crc;
`else
   assign w_crc_field = '0;
`endif

   always_comb begin
      debug_reg                          = '0;
      debug_reg[DBG_DONE_BIT]            = r_done;
      debug_reg[DBG_BTERR_BIT]           = r_bterr;
      debug_reg[DBG_BSERR_BIT]           = r_bserr;
      debug_reg[DBG_ISIZE_LSB +: 32]     = rev_endianess ? byte_swap32(r_isize) : r_isize;
      debug_reg[DBG_CRC_LSB +: 32]       = rev_endianess ? byte_swap32(w_crc_field) : w_crc_field;
      debug_reg[DBG_BSIZE_LSB +: 24]     = 24'(r_bsize);
   end

   assign in_if.ready     = w_in_ready;
   assign out_if.data     = r_out_data;
   assign out_if.valid    = r_out_valid;
   assign out_if.last     = r_out_last;
   assign out_if.blk_end  = r_out_blk_end;

endmodule

// File: tb/tb_gzip_stream_monitor.sv
// Self-checking bench for gzip_stream_monitor: directed and random streams against a
// stream-level reference model; CRC expectations follow GZIP_MON_CRC_EN.
module tb_gzip_stream_monitor;

   localparam int MAXLEN = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  btype = 2'b00;
   logic        rev = 1'b0;
   logic [95:0] dbg;

   gzip_stream_monitor_if s_in ();
   gzip_stream_monitor_if s_out ();

   gzip_stream_monitor #(
      .MAX_STORED_LEN (24'(MAXLEN)),
      .BLK_CNT_W      (24)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .btype         (btype),
      .rev_endianess (rev),
      .in_if         (s_in),
      .out_if        (s_out),
      .debug_reg     (dbg)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [7:0] s_data[$];
   bit         s_last[$];
   bit         s_blk[$];

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] swap32(input logic [31:0] x);
      return {x[7:0], x[15:8], x[23:16], x[31:24]};
   endfunction

   // Expected debug_reg after k deliveries of the current stream
   function automatic logic [95:0] model_dbg(input int k, input bit [1:0] bt, input bit rv);
      logic [31:0] crc;
      logic [31:0] isz;
      logic [31:0] crcf;
      logic [23:0] bs;
      int          seg;
      bit          err;
      bit          done;
      crc  = 32'hFFFFFFFF;
      seg  = 0;
      bs   = '0;
      err  = 1'b0;
      for (int j = 0; j < k; j++) begin
         crc = crc ^ {24'h0, s_data[j]};
         for (int b = 0; b < 8; b++) crc = crc[0] ? ((crc >> 1) ^ 32'hEDB88320) : (crc >> 1);
         seg++;
         if (bt == 2'b00 && seg > MAXLEN) err = 1'b1;
         if (s_blk[j] || s_last[j]) begin
            bs  = 24'(seg);
            seg = 0;
         end
      end
      done = (k > 0) && s_last[k-1];
      isz  = 32'(k);
`ifdef GZIP_MON_CRC_EN
      crcf = ~crc;
`else
      crcf = 32'h0;
`endif
      if (rv) begin
         isz  = swap32(isz);
         crcf = swap32(crcf);
      end
      return {bs, crcf, isz, 5'b0, err, 1'b0, done};
   endfunction

   task automatic fill(input int n, input int blk_idx, input bit rnd_blk);
      s_data.delete(); s_last.delete(); s_blk.delete();
      for (int i = 0; i < n; i++) begin
         s_data.push_back(8'($urandom_range(255)));
         s_last.push_back(i == n - 1);
         s_blk.push_back((i == blk_idx) || (rnd_blk && $urandom_range(3) == 0));
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      s_in.valid = 1'b0;
      #1;
      chk("rst_outputs", {s_in.ready, s_out.valid, s_out.data, s_out.last, s_out.blk_end, dbg}, '0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // mode 0: out_ready=1, 1: toggling 1010, 2: random
   task automatic run_stream(input bit [1:0] bt, input int mode, input int rst_after);
      int  n;
      int  sent;
      int  got;
      int  cyc;
      bit  pend;
      n    = s_data.size();
      sent = 0;
      got  = 0;
      cyc  = 0;
      pend = 1'b0;
      btype = bt;
      forever begin
         @(negedge clk);
         cyc++;
         if (cyc > 3000) begin
            chk("timeout_delivered", 128'(got), 128'(n));
            break;
         end
         if (pend) begin
            chk("debug_reg", dbg, model_dbg(got, bt, rev));
            pend = 1'b0;
            if (rst_after > 0 && got == rst_after) begin
               do_reset();
               return;
            end
         end
         if (got == n) break;
         if (sent < n) begin
            s_in.valid   = ($urandom_range(3) != 0);
            s_in.data    = s_data[sent];
            s_in.last    = s_last[sent];
            s_in.blk_end = s_blk[sent];
         end else begin
            s_in.valid   = 1'b1;
            s_in.data    = 8'hEE;
            s_in.last    = 1'b1;
            s_in.blk_end = 1'b1;
         end
         case (mode)
            0:       s_out.ready = 1'b1;
            1:       s_out.ready = cyc[0];
            default: s_out.ready = 1'($urandom_range(1));
         endcase
         #1;
         if (sent == n) chk("drain_in_ready", 128'(s_in.ready), 128'(0));
         if (s_out.valid && s_out.ready) begin
            chk("out_byte", {s_out.data, s_out.last, s_out.blk_end},
                {s_data[got], s_last[got], s_blk[got]});
            got++;
            pend = 1'b1;
         end
         if (s_in.valid && s_in.ready) sent++;
      end
      s_in.valid  = 1'b0;
      s_out.ready = 1'b0;
   endtask

   initial begin
      string str;
      s_in.valid = 1'b0; s_in.data = '0; s_in.last = 1'b0; s_in.blk_end = 1'b0;
      s_out.ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_state", {s_in.ready, s_out.valid, dbg}, '0);
      rst_n = 1'b1;

      // "123456789" known-answer stream
      str = "123456789";
      s_data.delete(); s_last.delete(); s_blk.delete();
      for (int i = 0; i < 9; i++) begin
         s_data.push_back(str[i]);
         s_last.push_back(i == 8);
         s_blk.push_back(1'b0);
      end
      run_stream(2'b00, 0, 0);
`ifdef GZIP_MON_CRC_EN
      chk("crc_kat", 128'(dbg[71:40]), 128'(32'hCBF43926));
`else
      chk("crc_off", 128'(dbg[71:40]), 128'(0));
`endif
      chk("isize_9", 128'(dbg[39:8]), 128'(9));
      chk("bsize_9", 128'(dbg[95:72]), 128'(9));
      chk("done_9", 128'(dbg[0]), 128'(1));

      rev = 1'b1;
      #1;
`ifdef GZIP_MON_CRC_EN
      chk("crc_rev", 128'(dbg[71:40]), 128'(32'h2639F4CB));
`endif
      chk("isize_rev", 128'(dbg[39:8]), 128'(32'h09000000));
      rev = 1'b0;

      // stored-block length limit crossed on the 5th delivery
      fill(6, -1, 1'b0);
      run_stream(2'b00, 2, 0);
      chk("bserr_set", 128'(dbg[2]), 128'(1));
      chk("bsize_6", 128'(dbg[95:72]), 128'(6));

      // throttled sink, block end on byte 8
      fill(16, 7, 1'b0);
      run_stream(2'b10, 1, 0);
      chk("isize_16", 128'(dbg[39:8]), 128'(16));
      chk("bsize_8", 128'(dbg[95:72]), 128'(8));
      chk("bserr_clr", 128'(dbg[2]), 128'(0));

      for (int r = 0; r < 6; r++) begin
         fill(1 + $urandom_range(19), -1, 1'b1);
         rev = 1'($urandom_range(1));
         run_stream(2'($urandom_range(2)), $urandom_range(2), 0);
      end
      rev = 1'b0;

      // reset after 3 deliveries, then a fresh stream
      fill(10, -1, 1'b0);
      run_stream(2'b01, 0, 3);
      chk("post_rst_dbg", dbg, '0);
      fill(5, 2, 1'b0);
      run_stream(2'b00, 0, 0);
      chk("post_rst_isize", 128'(dbg[39:8]), 128'(5));

      // reserved btype at stream start
      @(negedge clk);
      btype = 2'b11;
      s_out.ready = 1'b1;
      s_in.valid = 1'b1; s_in.data = 8'h55; s_in.last = 1'b0; s_in.blk_end = 1'b0;
      #1;
      chk("err_first_ready", 128'(s_in.ready), 128'(1));
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         #1;
         chk("err_state", {s_in.ready, s_out.valid, dbg}, {1'b0, 1'b0, 96'h2});
      end
      do_reset();
      @(negedge clk);
      chk("err_cleared", dbg, '0);
      fill(3, -1, 1'b0);
      run_stream(2'b01, 2, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
